rtc_poller: RTL and testbench

- Periodically sweeps the DS1302 timekeeping registers through the ds1302_2 serial driver's request/done handshake.
- Splits each BCD byte into tens and units digit codes and writes them into the dual-port display RAM that dispctl scans.
- Sits between the RTC driver (upstream) and the display memory (downstream).
- Runs while the controller is not editing time; the controller pauses it with hold.

---
 rtl/rtc_poller.sv | 176 +++++++++++++++++
 tb/tb_rtc_poller.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_poller.sv
// rtc_poller: sweeps the six DS1302 time registers and writes BCD digits into display RAM.
// Optional define RTC_POLLER_BCD_CHECK_EN blanks non-decimal nibbles and adds a sticky bcd_err output.
module rtc_poller #(
    parameter int unsigned POLL_DIV = 2500000,
    parameter int unsigned TIMEOUT  = 65535
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       hold,
    input  logic       kick,
    output logic [7:0] rtc_addr,
    output logic       rtc_ena,
    input  logic [7:0] rtc_r,
    input  logic       rtc_done,
    output logic [3:0] ram_addr,
    output logic [7:0] ram_w,
    output logic       ram_we,
    output logic       busy,
    output logic       sweep_done,
    output logic       err
`ifdef RTC_POLLER_BCD_CHECK_EN
    ,
    output logic       bcd_err
`endif
);

    localparam int unsigned DIV_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [2:0]  LAST  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_WR_HI, S_WR_LO, S_NEXT
    } state_t;

    state_t             state, state_nx;
    logic [2:0]         idx;
    logic [DIV_W-1:0]   div;
    logic [TMO_W-1:0]   wcnt;
    logic               pending;
    logic [7:0]         data;
    logic               err_q;
    logic               done_q;
    logic               tick;
    logic               timeout;
    logic [7:0]         masked;
    logic [3:0]         hi_c;
    logic [3:0]         lo_c;
`ifdef RTC_POLLER_BCD_CHECK_EN
    logic               bad_c;
    logic               bcd_err_q;
`endif

    function automatic logic [7:0] cmd_of(input logic [2:0] i);
        case (i)
            3'd0:    return 8'h81;
            3'd1:    return 8'h83;
            3'd2:    return 8'h85;
            3'd3:    return 8'h87;
            3'd4:    return 8'h89;
            3'd5:    return 8'h8D;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] mask_of(input logic [2:0] i);
        case (i)
            3'd0, 3'd1: return 8'h7F;
            3'd2, 3'd3: return 8'h3F;
            3'd4:       return 8'h1F;
            default:    return 8'hFF;
        endcase
    endfunction

    assign tick    = (div == DIV_W'(POLL_DIV - 1));
    assign timeout = (wcnt == TMO_W'(TIMEOUT - 1));

    // Digit split of the masked read byte
    always_comb begin
        masked = rtc_r & mask_of(idx);
`ifdef RTC_POLLER_BCD_CHECK_EN
        bad_c = (masked[7:4] > 4'd9) || (masked[3:0] > 4'd9);
        hi_c  = (masked[7:4] > 4'd9) ? 4'hF : masked[7:4];
        lo_c  = (masked[3:0] > 4'd9) ? 4'hF : masked[3:0];
`else
        hi_c  = masked[7:4];
        lo_c  = masked[3:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (clr) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Kick and tick are honoured in the same cycle so kick at t gives rtc_ena at t+1
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if ((pending || kick || tick) && !hold) state_nx = S_REQ;
            S_REQ:   state_nx = S_WAIT;
            S_WAIT:  begin
                if (rtc_done)     state_nx = S_WR_HI;
                else if (timeout) state_nx = S_NEXT;
            end
            S_WR_HI: state_nx = S_WR_LO;
            S_WR_LO: state_nx = S_NEXT;
            S_NEXT:  state_nx = (idx == LAST) ? S_IDLE : S_REQ;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            idx     <= '0;
            div     <= '0;
            wcnt    <= '0;
            pending <= 1'b1;
            data    <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef RTC_POLLER_BCD_CHECK_EN
            bcd_err_q <= 1'b0;
`endif
        end else begin
            div    <= tick ? '0 : div + 1'b1;
            wcnt   <= (state == S_WAIT) ? wcnt + 1'b1 : '0;
            done_q <= (state == S_NEXT) && (idx == LAST);
            if (state == S_IDLE && state_nx == S_REQ) pending <= 1'b0;
            else if (kick || tick)                    pending <= 1'b1;
            if (state == S_NEXT) idx <= (idx == LAST) ? 3'd0 : 3'(idx + 3'd1);
            if (state == S_WAIT && rtc_done) data <= {hi_c, lo_c};
            if (state == S_WAIT && !rtc_done && timeout) err_q <= 1'b1;
`ifdef RTC_POLLER_BCD_CHECK_EN
            if (state == S_WAIT && rtc_done && bad_c) bcd_err_q <= 1'b1;
`endif
        end
    end

    // Outputs forced low while clr is high so a reset mid-sweep cannot land a write
    always_comb begin
        rtc_addr = '0;
        rtc_ena  = 1'b0;
        ram_addr = '0;
        ram_w    = '0;
        ram_we   = 1'b0;
        busy     = 1'b0;
        if (!clr) begin
            busy = (state != S_IDLE);
            case (state)
                S_REQ: begin
                    rtc_addr = cmd_of(idx);
                    rtc_ena  = 1'b1;
                end
                S_WAIT:  rtc_addr = cmd_of(idx);
                S_WR_HI: begin
                    ram_we   = 1'b1;
                    ram_addr = {idx, 1'b0};
                    ram_w    = {4'h0, data[7:4]};
                end
                S_WR_LO: begin
                    ram_we   = 1'b1;
                    ram_addr = {idx, 1'b1};
                    ram_w    = {4'h0, data[3:0]};
                end
                default: ;
            endcase
        end
    end

    assign sweep_done = done_q & ~clr;
    assign err        = err_q & ~clr;
`ifdef RTC_POLLER_BCD_CHECK_EN
    assign bcd_err    = bcd_err_q & ~clr;
`endif

endmodule

// File: tb/tb_rtc_poller.sv
// tb_rtc_poller: directed bench for rtc_poller with a DS1302 driver model and a display RAM model.
module tb_rtc_poller;

    logic       clk = 1'b0;
    logic       clr, hold, kick;
    logic [7:0] rtc_addr;
    logic       rtc_ena;
    logic [7:0] rtc_r = 8'h00;
    logic       rtc_done = 1'b0;
    logic [3:0] ram_addr;
    logic [7:0] ram_w;
    logic       ram_we;
    logic       busy, sweep_done, err;
`ifdef RTC_POLLER_BCD_CHECK_EN
    logic       bcd_err;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] rtc_val [0:5];
    logic [7:0] silent_addr;
    logic [7:0] exp_cmd [0:5]  = '{8'h81, 8'h83, 8'h85, 8'h87, 8'h89, 8'h8D};
    logic [7:0] exp_ram [0:11] = '{8'h5, 8'h9, 8'h4, 8'h5, 8'h2, 8'h3,
                                   8'h3, 8'h1, 8'h1, 8'h2, 8'h2, 8'h4};

    logic [7:0] ram     [0:15]   = '{default: 8'hEE};
    int         wr_cnt  [0:15]   = '{default: 0};
    logic [7:0] ena_log [0:1023] = '{default: 8'h00};
    int         ena_total   = 0;
    int         sweep_total = 0;

    rtc_poller #(.POLL_DIV(400), .TIMEOUT(16)) dut (
        .clk(clk), .clr(clr), .hold(hold), .kick(kick),
        .rtc_addr(rtc_addr), .rtc_ena(rtc_ena), .rtc_r(rtc_r), .rtc_done(rtc_done),
        .ram_addr(ram_addr), .ram_w(ram_w), .ram_we(ram_we),
        .busy(busy), .sweep_done(sweep_done), .err(err)
`ifdef RTC_POLLER_BCD_CHECK_EN
        , .bcd_err(bcd_err)
`endif
    );

    always #5 clk = ~clk;

    // Driver model: answers two cycles after rtc_ena unless the command is silenced
    int         dly = 0;
    logic [7:0] pend = 8'h00;
    always @(negedge clk) begin
        rtc_done = 1'b0;
        if (clr) begin
            dly = 0;
        end else begin
            if (dly != 0) begin
                dly = dly - 1;
                if (dly == 0) begin
                    rtc_done = 1'b1;
                    rtc_r    = pend;
                end
            end
            if (rtc_ena && rtc_addr != silent_addr) begin
                dly = 2;
                case (rtc_addr)
                    8'h81:   pend = rtc_val[0];
                    8'h83:   pend = rtc_val[1];
                    8'h85:   pend = rtc_val[2];
                    8'h87:   pend = rtc_val[3];
                    8'h89:   pend = rtc_val[4];
                    8'h8D:   pend = rtc_val[5];
                    default: pend = 8'h00;
                endcase
            end
        end
    end

    // RAM and handshake monitor
    always @(posedge clk) begin
        if (ram_we) begin
            ram[ram_addr]    <= ram_w;
            wr_cnt[ram_addr] <= wr_cnt[ram_addr] + 1;
        end
        if (rtc_ena) begin
            ena_log[ena_total % 1024] <= rtc_addr;
            ena_total <= ena_total + 1;
        end
        if (sweep_done) sweep_total <= sweep_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_kick();
        kick = 1'b1;
        step(1);
        kick = 1'b0;
    endtask

    task automatic wait_sweep(input string tag, input int budget);
        int  n = 0;
        logic found = 1'b0;
        while (n < budget && !found) begin
            step(1);
            n++;
            if (sweep_done) found = 1'b1;
        end
        check({tag, "_sweep_done"}, 32'(found), 32'd1);
        check({tag, "_idle_at_done"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_ena(input string tag, input logic [7:0] a, input int budget);
        int  n = 0;
        logic found = 1'b0;
        while (n < budget && !found) begin
            step(1);
            n++;
            if (rtc_ena && rtc_addr == a) found = 1'b1;
        end
        check({tag, "_req_seen"}, 32'(found), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rtc_addr"}, 32'(rtc_addr), 32'h0);
        check({tag, "_rtc_ena"}, 32'(rtc_ena), 32'h0);
        check({tag, "_ram_we"}, 32'(ram_we), 32'h0);
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'h0);
        check({tag, "_ram_w"}, 32'(ram_w), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_sweep_done"}, 32'(sweep_done), 32'h0);
        check({tag, "_err"}, 32'(err), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, s0, w2, w3, w4;
        clr = 1'b1; hold = 1'b0; kick = 1'b0; silent_addr = 8'h00;
        rtc_val = '{8'h59, 8'h45, 8'h23, 8'h31, 8'h12, 8'h24};

        // Reset state
        step(3);
        check_all_zero("reset");
`ifdef RTC_POLLER_BCD_CHECK_EN
        check("reset_bcd_err", 32'(bcd_err), 32'h0);
`endif

        // First sweep starts right after clr falls
        e0 = ena_total; s0 = sweep_total;
        clr = 1'b0;
        step(1);
        check("first_req_ena", 32'(rtc_ena), 32'h1);
        check("first_req_addr", 32'(rtc_addr), 32'h81);
        step(3);
        check("sec_hi_we", 32'(ram_we), 32'h1);
        check("sec_hi_addr", 32'(ram_addr), 32'h0);
        check("sec_hi_data", 32'(ram_w), 32'h5);
        step(1);
        check("sec_lo_addr", 32'(ram_addr), 32'h1);
        check("sec_lo_data", 32'(ram_w), 32'h9);
        wait_sweep("sweep1", 200);
        step(1);
        check("sweep1_ena_count", 32'(ena_total - e0), 32'd6);
        for (int k = 0; k < 6; k++)
            check($sformatf("sweep1_cmd%0d", k), 32'(ena_log[(e0 + k) % 1024]), 32'(exp_cmd[k]));
        for (int a = 0; a < 12; a++)
            check($sformatf("sweep1_ram%0d", a), 32'(ram[a]), 32'(exp_ram[a]));
        check("unused_ram_writes", 32'(wr_cnt[12] + wr_cnt[13] + wr_cnt[14] + wr_cnt[15]), 32'd0);
        check("sweep1_count", 32'(sweep_total - s0), 32'd1);
        check("sweep1_busy_after", 32'(busy), 32'h0);

        // Masks strip the CH bit from seconds and the 12/24 bits from hours
        rtc_val[0] = 8'hD9; rtc_val[2] = 8'hA3;
        pulse_kick();
        check("kick_latency_ena", 32'(rtc_ena), 32'h1);
        check("kick_latency_addr", 32'(rtc_addr), 32'h81);
        wait_sweep("mask", 100);
        step(1);
        check("mask_ram0", 32'(ram[0]), 32'h5);
        check("mask_ram1", 32'(ram[1]), 32'h9);
        check("mask_ram4", 32'(ram[4]), 32'h2);
        check("mask_ram5", 32'(ram[5]), 32'h3);

        // Minutes never answered: timeout after 16 WAIT cycles, sweep continues
        silent_addr = 8'h83;
        w2 = wr_cnt[2]; w3 = wr_cnt[3]; w4 = wr_cnt[4];
        pulse_kick();
        wait_ena("tmo", 8'h83, 60);
        step(16);
        check("tmo_err_before", 32'(err), 32'h0);
        check("tmo_busy_wait", 32'(busy), 32'h1);
        check("tmo_addr_held", 32'(rtc_addr), 32'h83);
        step(1);
        check("tmo_err_set", 32'(err), 32'h1);
        step(1);
        check("tmo_next_ena", 32'(rtc_ena), 32'h1);
        check("tmo_next_addr", 32'(rtc_addr), 32'h85);
        wait_sweep("tmo", 100);
        step(1);
        check("tmo_ram2_writes", 32'(wr_cnt[2]), 32'(w2));
        check("tmo_ram3_writes", 32'(wr_cnt[3]), 32'(w3));
        check("tmo_ram4_writes", 32'(wr_cnt[4]), 32'(w4 + 1));
        check("tmo_ram2", 32'(ram[2]), 32'h4);
        check("tmo_ram3", 32'(ram[3]), 32'h5);
        check("tmo_err_sticky", 32'(err), 32'h1);
        silent_addr = 8'h00;

        // Hold blocks reset-pending, kicks and a tick; release gives one merged sweep
        hold = 1'b1; clr = 1'b1;
        step(2);
        clr = 1'b0;
        step(1);
        check("hold_err_cleared", 32'(err), 32'h0);
        e0 = ena_total; s0 = sweep_total;
        step(100);
        pulse_kick();
        step(200);
        pulse_kick();
        step(130);
        check("hold_no_ena", 32'(ena_total - e0), 32'd0);
        check("hold_not_busy", 32'(busy), 32'h0);
        hold = 1'b0;
        wait_sweep("hold", 100);
        step(1);
        check("hold_ena_count", 32'(ena_total - e0), 32'd6);
        check("hold_sweep_count", 32'(sweep_total - s0), 32'd1);
        step(80);
        check("hold_single_sweep", 32'(sweep_total - s0), 32'd1);

        // clr in the cycle after the minutes rtc_done aborts the writes
        w2 = wr_cnt[2]; w3 = wr_cnt[3];
        pulse_kick();
        wait_ena("abort", 8'h83, 60);
        step(3);
        clr = 1'b1;
        #1;
        check("abort_we_gated", 32'(ram_we), 32'h0);
        step(1);
        check_all_zero("abort");
        step(1);
        clr = 1'b0;
        e0 = ena_total;
        step(1);
        check("abort_restart_ena", 32'(rtc_ena), 32'h1);
        check("abort_restart_addr", 32'(rtc_addr), 32'h81);
        check("abort_ram2_writes", 32'(wr_cnt[2]), 32'(w2));
        check("abort_ram3_writes", 32'(wr_cnt[3]), 32'(w3));
        wait_sweep("abort", 100);
        step(1);
        check("abort_first_cmd", 32'(ena_log[e0 % 1024]), 32'h81);

        // Year with a non-decimal units nibble
        rtc_val[5] = 8'h3C;
        pulse_kick();
        wait_sweep("year", 100);
        step(1);
        check("year_ram10", 32'(ram[10]), 32'h3);
`ifdef RTC_POLLER_BCD_CHECK_EN
        check("year_ram11", 32'(ram[11]), 32'h0F);
        check("year_bcd_err", 32'(bcd_err), 32'h1);
`else
        check("year_ram11", 32'(ram[11]), 32'h0C);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
